// File: rtl/instr_pkg.sv
// Shared instruction types for the front end.
// Fetch entries carry the encoding, PC and fault flag.
package Instr;

    typedef logic [31:0] enc_t;

    typedef struct packed {
        enc_t        enc;
        logic [31:0] pc;
        logic        fault;
    } fetch_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fstate_e;

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of fetch entries with flush.
// A flush may coincide with a push; the pushed entry survives.
module fetch_queue
    import Instr::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          flush,
    input  logic          push,
    input  fetch_t        pushData,
    input  logic          pop,
    output logic          headValid,
    output fetch_t        head,
    output logic [CW-1:0] count
);

    fetch_t        mem [DEPTH];
    logic [AW:0]   rd;
    logic [AW:0]   wr;
    logic [AW:0]   used;

    assign used      = wr - rd;
    assign count     = CW'(used);
    assign headValid = (rd != wr);
    assign head      = mem[rd[AW-1:0]];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd  <= '0;
            wr  <= '0;
            mem <= '{default: '0};
        end else if (flush) begin
            rd <= '0;
            wr <= {{AW{1'b0}}, push};
            if (push) begin
                mem[0] <= pushData;
            end
        end else begin
            if (push) begin
                mem[wr[AW-1:0]] <= pushData;
                wr <= wr + 1'b1;
            end
            if (pop) begin
                rd <= rd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, credit-limited
// requests, response queue, redirects and fault entries.
module fetch_unit
    import Instr::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    input  logic        imemRspErr,
    output logic        outValid,
    input  logic        outReady,
    output enc_t        outEnc,
    output logic [31:0] outPc,
    output logic        outFault
);

    localparam int CW = $clog2(DEPTH + 1);

    fstate_e       state, stateN;
    logic [31:0]   pc, pcN;
    logic [31:0]   rspPc, rspPcN;
    logic [CW-1:0] inflight, inflightN, inflightAcc;
    logic [CW-1:0] drop, dropN, dropAcc;
    logic [CW-1:0] occ;
    logic [CW:0]   used;

    logic   reqFire, rspKeep, rspDrop, misaligned;
    logic   qPush, qPop, qFlush, qValid;
    fetch_t qIn, qHead;

    assign used         = {1'b0, occ} + {1'b0, inflight};
    assign imemReqValid = (state == RUN) && !redirectValid
                          && (used < (CW+1)'(DEPTH));
    assign imemReqAddr  = pc;
    assign reqFire      = imemReqValid && imemReqReady;
    assign rspKeep      = imemRspValid && (drop == '0);
    assign rspDrop      = imemRspValid && (drop != '0);
    assign misaligned   = |redirectPc[1:0];
    assign qPop         = qValid && outReady && !redirectValid;

    always_comb begin
        inflightAcc = inflight + CW'(reqFire) - CW'(rspKeep);
        dropAcc     = drop - CW'(rspDrop);
        stateN      = state;
        pcN         = pc;
        rspPcN      = rspPc;
        inflightN   = inflightAcc;
        dropN       = dropAcc;
        qPush       = 1'b0;
        qFlush      = 1'b0;
        qIn         = '0;
        if (reqFire) begin
            pcN = pc + 32'd4;
        end
        if (rspKeep) begin
            qPush  = 1'b1;
            qIn    = '{enc: imemRspErr ? '0 : imemRspData,
                       pc: rspPc, fault: imemRspErr};
            rspPcN = rspPc + 32'd4;
            // younger responses still in flight belong to a dead stream
            if (imemRspErr) begin
                stateN    = HALT;
                dropN     = inflightAcc;
                inflightN = '0;
            end
        end
        if (redirectValid) begin
            qFlush    = 1'b1;
            dropN     = dropAcc + inflightAcc;
            inflightN = '0;
            qPush     = misaligned;
            qIn       = '{enc: '0, pc: redirectPc, fault: 1'b1};
            if (misaligned) begin
                stateN = HALT;
            end else begin
                stateN = RUN;
                pcN    = redirectPc;
                rspPcN = redirectPc;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= RUN;
            pc       <= RESET_PC;
            rspPc    <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            state    <= stateN;
            pc       <= pcN;
            rspPc    <= rspPcN;
            inflight <= inflightN;
            drop     <= dropN;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rstN      (rstN),
        .flush     (qFlush),
        .push      (qPush),
        .pushData  (qIn),
        .pop       (qPop),
        .headValid (qValid),
        .head      (qHead),
        .count     (occ)
    );

    assign outValid = qValid;
    assign outEnc   = qValid ? qHead.enc   : '0;
    assign outPc    = qValid ? qHead.pc    : '0;
    assign outFault = qValid ? qHead.fault : 1'b0;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. It generates sequential PCs, issues word requests to the instruction memory port, and buffers returned words in a small queue. It presents one `Instr::enc_t` per cycle to the decoder over a valid/ready handshake. It also handles redirects from the back end, discarding stale in-flight responses, and turns memory errors and misaligned targets into fault entries.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC fetched after reset.
- `DEPTH`, 4, queue entries and maximum outstanding requests; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `redirectValid`  in  1  flush and restart fetch.
- `redirectPc`  in  32  new fetch PC.
- `imemReqValid`  out  1  request valid.
- `imemReqReady`  in  1  memory accepts request.
- `imemReqAddr`  out  32  word address (byte PC, bits [1:0]=0).
- `imemRspValid`  in  1  response valid; responses are in order, no backpressure.
- `imemRspData`  in  32  instruction word.
- `imemRspErr`  in  1  access fault for this response.
- `outValid`  out  1  queue head valid.
- `outReady`  in  1  decoder accepts head.
- `outEnc`  out  `Instr::enc_t`  instruction word; 0 for fault entries.
- `outPc`  out  32  PC of head.
- `outFault`  out  1  head is a fault entry (fetch error or misaligned PC).

## Operation
- State: `pc`, 2-state FSM {RUN, HALT}, queue, `inflight`, `drop`; all counters are `$clog2(DEPTH+1)` bits wide.
- Credit rule: `imemReqValid = (state==RUN) && !redirectValid && (occupancy + inflight < DEPTH)`. A response therefore always has a free slot.
- On request handshake: `pc += 4` (wraps modulo 2^32); `inflight++`.
- On response:
  - If `drop>0`: `drop--`; the response is discarded.
  - Otherwise `inflight--` and the entry {data, PC, err} is enqueued. PCs are tracked by a PC FIFO shadowing in-flight requests, or equivalently by the queue tail PC.
  - Error response: enqueue a fault entry and go to HALT. Set `drop = inflight-1` (younger responses are discarded) and `inflight = 0`.
- Redirect (highest priority):
  - Flush the queue and set `drop = drop + inflight` (after this cycle's response accounting); `inflight = 0`.
  - If `redirectPc[1:0]==0`: `pc = redirectPc`, state RUN.
  - Otherwise enqueue one fault entry with `outPc = redirectPc` and go to HALT.
- HALT issues no requests; it exits only on a redirect.
- Dequeue on `outValid && outReady`. Any dequeue in a redirect cycle is overridden by the flush.
- Simultaneous enqueue and dequeue keep occupancy unchanged. A full queue cannot receive an enqueue (credit rule).

## Timing
- Reset values: `pc=RESET_PC`, RUN, queue empty, `inflight=drop=0`, `outValid=0`, `outFault=0`, `outEnc=0`, `outPc=0`.
- `imemReqValid` is asserted from the first cycle after `rstN` deasserts, with `imemReqAddr=RESET_PC`.
- `imemReqAddr` is driven directly from the `pc` register.
- Response in cycle N → `outValid` in N+1 if the queue was empty. There is no bypass.
- Dequeue in cycle N → the freed credit can issue a request in N+1.
- Redirect in cycle N:
  - `outValid=0` in N+1 unless a fault entry is enqueued.
  - The request to `redirectPc` is issued in N+1.
  - A response arriving in cycle N belongs to the old stream and is dropped.
- Reset mid-operation clears everything. The memory side must also reset, since outstanding responses are not tracked across reset.

## Structure
- `Instr` package: add `fetch_t` struct {`enc_t enc; logic [31:0] pc; logic fault;`}.
- Sub-module `fetch_queue`: parameterised synchronous FIFO of `fetch_t` with `DEPTH` entries, flush input, and occupancy output. Pointers are `$clog2(DEPTH)` bits plus a wrap bit.
- The FSM, credit counters and PC logic live in `fetch_unit`.

## Test plan
- Reset, then `imemReqReady=1` with 1-cycle response latency and `outReady=1` → requests to 0,4,8,…; decoder sees `outPc` 0,4,8 one cycle after each response.
- `outReady=0`, memory always ready → exactly 4 requests issued, queue full, `imemReqValid=0`. Release `outReady` for 1 cycle → one new request the next cycle.
- 3 requests in flight, redirect to 0x100 → 3 late responses dropped; first `outPc=0x100` with the data of the 0x100 request.
- Redirect to 0x102 → a single entry `outFault=1`, `outPc=0x102`, no requests until the next redirect to 0x200.
- Response with `imemRspErr=1` at PC 0x8 while 0xC and 0x10 are in flight → fault entry at 0x8, the next two responses discarded, HALT.
- Redirect in the same cycle as a response and an `outReady` handshake → queue empty next cycle; the response is dropped; the next request goes to `redirectPc`.
